inv_sub_bytes_iter: RTL and testbench



---
 rtl/inv_sub_bytes_iter.sv | 149 ++++++++++++++
 tb/tb_inv_sub_bytes_iter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes_iter.sv
// inv_sub_bytes_iter
// Iterative inverse SubBytes engine for the AES-128 decryption datapath.
// A 128-bit state is accepted over a valid/ready handshake. It is passed
// through the FIPS-197 inverse S-box, LANES bytes per clock, starting with
// the MSB byte. The result is then presented over a second valid/ready
// handshake to the InvShiftRows/AddRoundKey stage.
//
// Ports:
//   clk_i        clock, all state updates on posedge
//   rst_n_i      asynchronous active-low reset
//   in_valid_i   input state valid
//   in_ready_o   engine can accept a state
//   state_i      input state, byte 0 = [127:120]
//   out_valid_o  result valid
//   out_ready_i  downstream accepts result
//   state_o      inverse-substituted state, same byte ordering
//   busy_o       high while substitution is in progress
module inv_sub_bytes_iter #(
  parameter int TEXT_WIDTH = 128,
  parameter int BYTE_WIDTH = 8,
  parameter int LANES      = 4,
  parameter int ITER       = 16 / LANES
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [TEXT_WIDTH-1:0] state_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [TEXT_WIDTH-1:0] state_o,
  output logic                  busy_o
);

  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } fsm_t;

  fsm_t                  fsm_q, fsm_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [TEXT_WIDTH-1:0] work_q, work_d;
  logic [TEXT_WIDTH-1:0] result_q, result_d;
  logic                  out_valid_q, out_valid_d;
  logic [TEXT_WIDTH-1:0] subst;
  int                    lane_lsb;

  // Working register with the current group of LANES bytes replaced.
  // Byte index cnt*LANES+l lives at bits counted down from the MSB.
  always_comb begin
    subst    = work_q;
    lane_lsb = 0;
    for (int l = 0; l < LANES; l++) begin
      lane_lsb = TEXT_WIDTH - BYTE_WIDTH * (int'(cnt_q) * LANES + l + 1);
      subst[lane_lsb +: BYTE_WIDTH] = INV_SBOX[work_q[lane_lsb +: BYTE_WIDTH]];
    end
  end

  always_comb begin
    fsm_d       = fsm_q;
    cnt_d       = cnt_q;
    work_d      = work_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    in_ready_o  = 1'b0;
    busy_o      = 1'b0;
    case (fsm_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          work_d = state_i;
          cnt_d  = '0;
          fsm_d  = BUSY;
        end
      end
      BUSY: begin
        busy_o = 1'b1;
        work_d = subst;
        if (cnt_q == CNT_LAST) begin
          result_d    = subst;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          fsm_d       = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        // Ready follows the downstream so a new block can enter on the
        // same edge the finished one leaves.
        in_ready_o = out_ready_i;
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          if (in_valid_i) begin
            work_d = state_i;
            cnt_d  = '0;
            fsm_d  = BUSY;
          end else begin
            fsm_d = IDLE;
          end
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fsm_q       <= IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign state_o     = result_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// tb_inv_sub_bytes_iter
// Directed bench for inv_sub_bytes_iter. Three instances share the clock,
// reset and state bus: LANES=4 (main), LANES=1 and LANES=16. Each instance
// has its own handshake signals. Expected values are hand-computed
// constants. Random blocks are built as forward-S-box images of random
// bytes, so the expected result is the original bytes.
module tb_inv_sub_bytes_iter;

  localparam logic [7:0] FWD_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [127:0] VEC2_IN  = 128'h00010203_04050607_08090A0B_0C0D0E0F;
  localparam logic [127:0] VEC2_OUT = 128'h52096AD5_3036A538_BF40A39E_81F3D7FB;
  localparam logic [127:0] VEC3_IN  = 128'h0001637C_EDFF0001_637CEDFF_0001637C;
  localparam logic [127:0] VEC3_OUT = 128'h52090001_537D5209_0001537D_52090001;
  localparam logic [127:0] ED_IN    = {16{8'hED}};
  localparam logic [127:0] ED_OUT   = {16{8'h53}};

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [127:0] state_in = '0;
  logic [2:0]   in_valid = '0;
  logic [2:0]   out_ready = '0;
  logic [2:0]   in_ready;
  logic [2:0]   out_valid;
  logic [2:0]   busy;
  logic [127:0] res [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  inv_sub_bytes_iter #(.LANES(4)) dut_l4 (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .state_i(state_in), .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
    .state_o(res[0]), .busy_o(busy[0])
  );

  inv_sub_bytes_iter #(.LANES(1)) dut_l1 (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .state_i(state_in), .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
    .state_o(res[1]), .busy_o(busy[1])
  );

  inv_sub_bytes_iter #(.LANES(16)) dut_l16 (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
    .state_i(state_in), .out_valid_o(out_valid[2]), .out_ready_i(out_ready[2]),
    .state_o(res[2]), .busy_o(busy[2])
  );

  function automatic logic [127:0] fwdState(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = FWD_SBOX[s[8*i +: 8]];
    return r;
  endfunction

  task automatic waitCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int d, input logic v, input logic [127:0] din, input logic rdy);
    in_valid[d]  = v;
    state_in     = din;
    out_ready[d] = rdy;
  endtask

  // Offers one block, scrambles state_in after the accept edge, and counts
  // edges from accept until out_valid rises (-1 when the bound expires).
  task automatic runBlock(input int d, input logic [127:0] din, output int lat, output logic [127:0] r);
    checkOutput($sformatf("accept_ready_%0d", d), {127'b0, in_ready[d]}, 128'd1);
    in_valid[d] = 1'b1;
    state_in    = din;
    waitCycle;
    in_valid[d] = 1'b0;
    state_in    = ~din;
    lat = 0;
    do begin
      waitCycle;
      lat++;
    end while (!out_valid[d] && lat < 40);
    if (!out_valid[d]) lat = -1;
    r = res[d];
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int           lat;
    int           cyc;
    int           acc;
    int           outs;
    int           last_acc;
    logic         pre;
    logic [127:0] r;
    logic [127:0] xs [8];
    logic [127:0] ins [8];

    // Reset state
    #2 rst_n = 1'b0;
    #10;
    checkOutput("reset_in_ready", {127'b0, in_ready[0]}, 128'd1);
    checkOutput("reset_out_valid", {127'b0, out_valid[0]}, 128'd0);
    checkOutput("reset_busy", {127'b0, busy[0]}, 128'd0);
    checkOutput("reset_state_o", res[0], 128'd0);
    waitCycle;
    rst_n = 1'b1;
    waitCycle;

    // All 0x63 bytes invert to zero
    applyStimulus(0, 1'b0, '0, 1'b1);
    runBlock(0, {16{8'h63}}, lat, r);
    checkOutput("s1_latency", 128'(lat), 128'd4);
    checkOutput("s1_result", r, 128'd0);
    waitCycle;
    checkOutput("s1_idle_valid", {127'b0, out_valid[0]}, 128'd0);
    checkOutput("s1_idle_ready", {127'b0, in_ready[0]}, 128'd1);

    // First ROM row
    runBlock(0, VEC2_IN, lat, r);
    checkOutput("s2_latency", 128'(lat), 128'd4);
    checkOutput("s2_result", r, VEC2_OUT);
    waitCycle;

    // Stall in DONE with a pending upstream block
    applyStimulus(0, 1'b0, '0, 1'b0);
    runBlock(0, VEC3_IN, lat, r);
    checkOutput("s3_latency", 128'(lat), 128'd4);
    checkOutput("s3_result", r, VEC3_OUT);
    applyStimulus(0, 1'b1, ED_IN, 1'b0);
    for (int i = 0; i < 10; i++) begin
      waitCycle;
      checkOutput("s3_stall_valid", {127'b0, out_valid[0]}, 128'd1);
      checkOutput("s3_stall_state", res[0], VEC3_OUT);
      checkOutput("s3_stall_ready", {127'b0, in_ready[0]}, 128'd0);
    end
    applyStimulus(0, 1'b1, ED_IN, 1'b1);
    #1;
    checkOutput("s3_comb_ready", {127'b0, in_ready[0]}, 128'd1);
    waitCycle;
    checkOutput("s3_b2b_busy", {127'b0, busy[0]}, 128'd1);
    checkOutput("s3_b2b_valid_drop", {127'b0, out_valid[0]}, 128'd0);
    applyStimulus(0, 1'b0, '0, 1'b1);
    lat = 0;
    do begin
      waitCycle;
      lat++;
    end while (!out_valid[0] && lat < 40);
    checkOutput("s3_b2b_latency", 128'(lat), 128'd4);
    checkOutput("s3_b2b_result", res[0], ED_OUT);
    waitCycle;

    // Streamed random blocks; the DONE cycle carries the handshake, so
    // consecutive accepts are ITER+1 edges apart.
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < 16; i++) xs[b][8*i +: 8] = 8'($urandom_range(0, 255));
      ins[b] = fwdState(xs[b]);
    end
    applyStimulus(0, 1'b1, ins[0], 1'b1);
    acc = 0;
    outs = 0;
    last_acc = 0;
    cyc = 0;
    while (outs < 8 && cyc < 200) begin
      pre = in_ready[0] && in_valid[0];
      waitCycle;
      cyc++;
      if (pre) begin
        if (acc > 0) checkOutput("s4_accept_spacing", 128'(cyc - last_acc), 128'd5);
        last_acc = cyc;
        acc++;
        if (acc < 8) state_in = ins[acc];
        else in_valid[0] = 1'b0;
      end
      if (out_valid[0]) begin
        checkOutput($sformatf("s4_result_%0d", outs), res[0], xs[outs]);
        checkOutput($sformatf("s4_roundtrip_%0d", outs), fwdState(res[0]), ins[outs]);
        outs++;
      end
    end
    checkOutput("s4_block_count", 128'(outs), 128'd8);
    waitCycle;

    // Reset during BUSY discards the block
    applyStimulus(0, 1'b1, VEC3_IN, 1'b1);
    waitCycle;
    in_valid[0] = 1'b0;
    waitCycle;
    waitCycle;
    checkOutput("s5_busy_before", {127'b0, busy[0]}, 128'd1);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("s5_busy", {127'b0, busy[0]}, 128'd0);
    checkOutput("s5_in_ready", {127'b0, in_ready[0]}, 128'd1);
    checkOutput("s5_out_valid", {127'b0, out_valid[0]}, 128'd0);
    checkOutput("s5_state_o", res[0], 128'd0);
    for (int i = 0; i < 4; i++) begin
      waitCycle;
      checkOutput("s5_no_pulse", {127'b0, out_valid[0]}, 128'd0);
    end
    rst_n = 1'b1;
    waitCycle;
    checkOutput("s5_no_pulse_after", {127'b0, out_valid[0]}, 128'd0);
    runBlock(0, VEC2_IN, lat, r);
    checkOutput("s5_latency", 128'(lat), 128'd4);
    checkOutput("s5_result", r, VEC2_OUT);
    waitCycle;

    // LANES=1 and LANES=16 builds
    out_ready[1] = 1'b1;
    runBlock(1, VEC2_IN, lat, r);
    checkOutput("s6_l1_latency", 128'(lat), 128'd16);
    checkOutput("s6_l1_result", r, VEC2_OUT);
    waitCycle;
    out_ready[2] = 1'b1;
    runBlock(2, VEC2_IN, lat, r);
    checkOutput("s6_l16_latency", 128'(lat), 128'd1);
    checkOutput("s6_l16_result", r, VEC2_OUT);
    waitCycle;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
